// File: rtl/calc_sequencer.sv
// calc_sequencer: multi-cycle signed * / + - % with display range check (ERR_CODE on error).
// Latency: done 3 edges after start for +,-,invalid; 34 edges for *,/,% (remainder only with CALC_MODULO_EN).
// Backpressure: start is honoured only in IDLE; pulses while busy are dropped, not queued.
module calc_sequencer (
  input  logic        sw_clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] operand1_i,
  input  logic [31:0] operand2_i,
  input  logic [2:0]  operator_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] ans_o,
  output logic        err_o
);

  localparam logic signed [31:0] MAX_POS  = 32'sd999999;
  localparam logic signed [31:0] MIN_NEG  = -32'sd99999;
  localparam logic [31:0]        ERR_CODE = 32'h00EE_0000;
  localparam logic [2:0] OP_MUL = 3'd1;
  localparam logic [2:0] OP_DIV = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
`ifdef CALC_MODULO_EN
  localparam logic [2:0] OP_MOD = 3'd5;
`endif

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_SIGN, S_CHECK, S_DONE} state_t;

  state_t      state_q;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;          // raw operands, used by the add/sub path
  logic [31:0] mag1_q, mag2_q;    // operand magnitudes for the iterative paths
  logic        s1_q, s2_q;
  logic [5:0]  cnt_q;
  logic [63:0] acc_q;             // product, or {partial remainder, quotient}
  logic [31:0] res_q;
  logic        ovf_q;
  logic        busy_q, done_q, err_q;
  logic [31:0] ans_q;

  logic [31:0] mag1_d, mag2_d;
  logic        long_d;
  logic [4:0]  idx;
  logic [63:0] addend;
  logic [32:0] trial, sum33;
  logic [63:0] acc_d;
  logic [31:0] res_d;
  logic        ovf_d;
  logic        op_valid, div_zero, in_range, err_d;

  // Decode of the request presented in IDLE: magnitudes and loop length.
  always_comb begin
    mag1_d = operand1_i[31] ? (~operand1_i + 32'd1) : operand1_i;
    mag2_d = operand2_i[31] ? (~operand2_i + 32'd1) : operand2_i;
    long_d = (operator_i == OP_MUL) || (operator_i == OP_DIV);
`ifdef CALC_MODULO_EN
    long_d = long_d || (operator_i == OP_MOD);
`endif
  end

  // One EXEC step of the shared datapath: add/sub, shift-add, or restoring-divide.
  always_comb begin
    idx    = 5'(6'd32 - cnt_q);   // multiplier bit consumed this step, LSB first
    addend = mag2_q[idx] ? ({32'd0, mag1_q} << idx) : 64'd0;
    // Shift {rem, dividend} left by one and try to subtract the divisor.
    trial  = acc_q[63:31] - {1'b0, mag2_q};
    sum33  = (op_q == OP_SUB) ? ({a_q[31], a_q} - {b_q[31], b_q})
                              : ({a_q[31], a_q} + {b_q[31], b_q});
    acc_d  = acc_q;
    case (op_q)
      OP_MUL: acc_d = acc_q + addend;
`ifdef CALC_MODULO_EN
      OP_DIV, OP_MOD:
`else
      OP_DIV:
`endif
        acc_d = trial[32] ? {acc_q[62:0], 1'b0} : {trial[31:0], acc_q[30:0], 1'b1};
      default: acc_d = {{31{sum33[32]}}, sum33};
    endcase
  end

  // Sign application; magnitudes with bit 31 set are far outside the display range.
  always_comb begin
    res_d = acc_q[31:0];
    ovf_d = 1'b0;
    case (op_q)
      OP_MUL: begin
        ovf_d = (|acc_q[63:32]) | acc_q[31];
        res_d = (s1_q ^ s2_q) ? -acc_q[31:0] : acc_q[31:0];
      end
      OP_DIV: begin
        ovf_d = acc_q[31];
        res_d = (s1_q ^ s2_q) ? -acc_q[31:0] : acc_q[31:0];
      end
`ifdef CALC_MODULO_EN
      // Remainder follows the dividend's sign (truncating division).
      OP_MOD: res_d = s1_q ? -acc_q[63:32] : acc_q[63:32];
`endif
      default: ovf_d = acc_q[32] ^ acc_q[31];
    endcase
  end

  // Error conditions evaluated in CHECK.
  always_comb begin
    op_valid = (op_q >= OP_MUL) && (op_q <= OP_SUB);
    div_zero = (op_q == OP_DIV) && (mag2_q == 32'd0);
`ifdef CALC_MODULO_EN
    op_valid = op_valid || (op_q == OP_MOD);
    div_zero = div_zero || ((op_q == OP_MOD) && (mag2_q == 32'd0));
`endif
    in_range = ($signed(res_q) >= MIN_NEG) && ($signed(res_q) <= MAX_POS);
    err_d    = !op_valid || div_zero || ovf_q || !in_range;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge sw_clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      op_q    <= 3'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      mag1_q  <= 32'd0;
      mag2_q  <= 32'd0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      cnt_q   <= 6'd0;
      acc_q   <= 64'd0;
      res_q   <= 32'd0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ans_q   <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          op_q    <= operator_i;
          a_q     <= operand1_i;
          b_q     <= operand2_i;
          mag1_q  <= mag1_d;
          mag2_q  <= mag2_d;
          s1_q    <= operand1_i[31];
          s2_q    <= operand2_i[31];
          cnt_q   <= long_d ? 6'd32 : 6'd1;
          // Multiply accumulates from zero; divide starts with the dividend in the low half.
          acc_q   <= (operator_i == OP_MUL) ? 64'd0 : {32'd0, mag1_d};
          busy_q  <= 1'b1;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q - 6'd1;
          if (cnt_q == 6'd1) state_q <= S_SIGN;
        end
        S_SIGN: begin
          res_q   <= res_d;
          ovf_q   <= ovf_d;
          state_q <= S_CHECK;
        end
        S_CHECK: begin
          err_q   <= err_d;
          ans_q   <= err_d ? ERR_CODE : res_q;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign ans_o  = ans_q;
  assign err_o  = err_q;

endmodule
